// File: rtl/histogram_2d.sv
// histogram_2d: per-frame pixel histogram with a cumulative (CDF) readout table rebuilt after each frame.
// Optional HIST_READY_EN adds a one-cycle hist_ready pulse when the table rebuild completes.
module histogram_2d #(
  parameter int DW = 8,
  parameter int IH = 512,
  parameter int IW = 640,
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          vsync,
  input  logic [DW-1:0] hist_cnt_addr,
  output logic [TW-1:0] hist_cnt_out
`ifdef HIST_READY_EN
  ,
  output logic          hist_ready
`endif
);
  localparam int NB = 1 << DW;
  localparam longint unsigned NPIX = longint'(IW) * longint'(IH);
  if (TW < 64 && NPIX >= (64'd1 << TW)) begin : g_size_check
    $error("histogram_2d: IW*IH must be below 2^TW");
  end
  logic [TW-1:0] cnt [NB];
  logic [TW-1:0] cdf [NB];
  logic          vsync_r;
  logic          busy;
  logic [DW-1:0] idx;
  logic [TW-1:0] sum;
  logic [TW-1:0] sum_nxt;
  logic          frame_end;
  logic          count_en;
  logic          last;
  // a falling vsync edge seen while the pass runs is deliberately dropped
  assign frame_end    = vsync_r & ~vsync & ~busy;
  assign count_en     = din_valid & vsync & ~busy;
  assign last         = busy & (&idx);
  assign sum_nxt      = sum + cnt[idx];
  assign hist_cnt_out = cdf[hist_cnt_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vsync_r <= 1'b0;
      busy    <= 1'b0;
      idx     <= '0;
      sum     <= '0;
    end else begin
      vsync_r <= vsync;
      busy    <= frame_end ? 1'b1 : busy & ~last;
      idx     <= frame_end ? '0 : busy ? idx + 1'b1 : idx;
      sum     <= frame_end ? '0 : busy ? sum_nxt : sum;
    end
  // pass writes the running sum into CDF and clears the bin it just consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
        cdf[i] <= '0;
      end
    end else if (busy) begin
      cdf[idx] <= sum_nxt;
      cnt[idx] <= '0;
    end else if (count_en) begin
      cnt[din] <= cnt[din] + TW'(1);
    end
`ifdef HIST_READY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hist_ready <= 1'b0;
    else        hist_ready <= last;
`endif
endmodule

// File: tb/tb_histogram_2d.sv
// tb_histogram_2d: directed frames checked through a scoreboard of expected CDF reads.
module tb_histogram_2d;
  localparam int DW = 8, IW = 4, IH = 2, TW = 32, NB = 256;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          din_valid = 1'b0;
  logic          vsync = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] hist_cnt_addr = '0;
  logic [TW-1:0] hist_cnt_out;
`ifdef HIST_READY_EN
  logic          hist_ready;
`endif
  typedef struct {
    logic [DW-1:0] addr;
    logic [TW-1:0] val;
    string         tag;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned m_cnt [NB];
  int unsigned m_cdf [NB];
  int unsigned m_new [NB];

  histogram_2d #(.DW(DW), .IH(IH), .IW(IW), .TW(TW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din_valid(din_valid),
    .din(din),
    .vsync(vsync),
    .hist_cnt_addr(hist_cnt_addr),
    .hist_cnt_out(hist_cnt_out)
`ifdef HIST_READY_EN
    ,
    .hist_ready(hist_ready)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int a, input logic [TW-1:0] v);
    exp_t e;
    e.addr = DW'(a);
    e.val  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic drain;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      hist_cnt_addr = e.addr;
      #1;
      cmp(e.tag, hist_cnt_out, e.val);
    end
  endtask

  task automatic pix(input logic v, input logic vs, input logic [DW-1:0] d);
    @(negedge clk);
    din_valid = v;
    vsync     = vs;
    din       = d;
    if (v && vs) m_cnt[d]++;
  endtask

  function automatic void model_pass;
    int unsigned s;
    s = 0;
    for (int i = 0; i < NB; i++) begin
      s += m_cnt[i];
      m_new[i] = s;
      m_cnt[i] = 0;
    end
  endfunction

  // junk pixels (din=7, valid) keep arriving while vsync is low and must be ignored
  task automatic drop;
    @(negedge clk);
    vsync     = 1'b0;
    din_valid = 1'b1;
    din       = 8'd7;
    model_pass();
  endtask

  task automatic end_frame;
    drop();
    for (int k = 0; k <= 257; k++) begin
      @(negedge clk);
`ifdef HIST_READY_EN
      cmp("hist_ready", TW'(hist_ready), TW'(k == 256));
`endif
    end
    for (int i = 0; i < NB; i++) m_cdf[i] = m_new[i];
  endtask

  initial begin
    logic [DW-1:0] f1 [8];
    f1 = '{8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd255, 8'd10, 8'd10};
    for (int i = 0; i < NB; i++) begin
      m_cnt[i] = 0;
      m_cdf[i] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push("rst_a0", 0, 0);
    push("rst_a128", 128, 0);
    push("rst_a255", 255, 0);
    drain();
`ifdef HIST_READY_EN
    cmp("hist_ready_rst", TW'(hist_ready), '0);
`endif
    for (int i = 0; i < 8; i++) pix(1'b1, 1'b1, f1[i]);
    end_frame();
    push("f1_cdf0", 0, 2);
    push("f1_cdf4", 4, 2);
    push("f1_cdf5", 5, 5);
    push("f1_cdf9", 9, 5);
    push("f1_cdf10", 10, 7);
    push("f1_cdf254", 254, 7);
    push("f1_cdf255", 255, 8);
    push("f1_model128", 128, m_cdf[128]);
    drain();
    for (int i = 0; i < 8; i++) pix(1'b1, 1'b1, 8'd3);
    end_frame();
    push("f2_cdf0", 0, 0);
    push("f2_cdf2", 2, 0);
    push("f2_cdf3", 3, 8);
    push("f2_cdf255", 255, 8);
    drain();
    pix(1'b1, 1'b0, 8'd7);
    pix(1'b1, 1'b0, 8'd7);
    pix(1'b1, 1'b1, 8'd1);
    pix(1'b0, 1'b1, 8'd7);
    pix(1'b1, 1'b1, 8'd2);
    pix(1'b0, 1'b1, 8'd7);
    pix(1'b1, 1'b1, 8'd7);
    end_frame();
    push("f3_cdf1", 1, m_cdf[1]);
    push("f3_cdf6", 6, m_cdf[6]);
    push("f3_cdf7", 7, 3);
    push("f3_cdf255", 255, m_cdf[255]);
    drain();
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 8'd20);
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 8'd200);
    drop();
    repeat (100) @(negedge clk);
    push("mid_new50", 50, m_new[50]);
    push("mid_new98", 98, m_new[98]);
    push("mid_old99", 99, m_cdf[99]);
    push("mid_old200", 200, m_cdf[200]);
    drain();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NB; i++) begin
      m_cdf[i] = 0;
      m_cnt[i] = 0;
    end
    push("rst_mid_a0", 0, 0);
    push("rst_mid_a50", 50, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    push("post_rst_a0", 0, 0);
    push("post_rst_a50", 50, 0);
    push("post_rst_a200", 200, 0);
    push("post_rst_a255", 255, 0);
    drain();
`ifdef HIST_READY_EN
    cmp("hist_ready_rst2", TW'(hist_ready), '0);
`endif
    pix(1'b1, 1'b1, 8'd9);
    end_frame();
    push("f5_cdf8", 8, 0);
    push("f5_cdf9", 9, 1);
    push("f5_cdf200", 200, m_cdf[200]);
    push("f5_cdf255", 255, 1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/histogram_2d.md
HISTOGRAM_2D -- requirements
Module: histogram_2d

Interface
REQ-001 SHALL have parameter DW, default 8, pixel bit width (2^DW bins).
REQ-002 SHALL have parameter IH, default 512, frame height in lines.
REQ-003 SHALL have parameter IW, default 640, frame width in pixels.
REQ-004 SHALL have parameter TW, default 32, bin/count word width; IW*IH < 2^TW is required.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port din_valid  input  1  din carries a pixel this cycle.
REQ-008 SHALL have port din  input  DW  pixel value.
REQ-009 SHALL have port vsync  input  1  high during active frame; falling edge = frame end.
REQ-010 SHALL have port hist_cnt_addr  input  DW  cumulative-table read address.
REQ-011 SHALL have port hist_cnt_out  output  TW  cumulative count at hist_cnt_addr.

Function
REQ-012 SHALL hold a count table CNT[0..2^DW-1] and a cumulative table CDF[0..2^DW-1], each TW bits wide.
REQ-013 SHALL, on each rising edge where din_valid=1, vsync=1 and no pass is running, increment CNT[din] by 1, wrapping modulo 2^TW.
REQ-014 SHALL ignore din_valid while vsync=0 or while a pass is running.
REQ-015 SHALL register vsync as vsync_r and detect frame end on the edge sampling vsync_r=1, vsync=0 (edge E0).
REQ-016 SHALL run the pass on edges E1..E(2^DW), processing bin i=0..2^DW-1 on edge E(i+1).
REQ-017 SHALL, for each bin i of the pass, write CDF[i] = CNT[0]+...+CNT[i] using a TW-bit running sum that starts at 0.
REQ-018 SHALL clear CNT[i] to 0 when bin i is processed.
REQ-019 SHALL drive hist_cnt_out combinationally as CDF[hist_cnt_addr], with zero-cycle read latency.
REQ-020 SHALL, on reads during a pass, return the already-updated value for processed bins and the previous frame's value for unprocessed bins.
REQ-021 SHALL complete a running pass even if vsync rises again; counting resumes on the edge after E(2^DW).
REQ-022 SHALL ignore a vsync falling edge that occurs during a pass.
REQ-023 SHALL count a pixel presented on the last cycle with vsync=1.
REQ-024 SHALL require vertical blanking of at least 2^DW+1 cycles for lossless operation.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously clear CNT, CDF, vsync_r, the running sum and the pass state.
REQ-026 SHALL hold hist_cnt_out at 0 for every address from reset until the first completed pass.
REQ-027 SHALL, on reset during a pass, abort the pass and zero both tables.

Configuration
REQ-028 SHALL, when macro HIST_READY_EN is defined, add output hist_ready (1 bit, reset 0).
REQ-029 SHALL, with HIST_READY_EN defined, pulse hist_ready high for exactly one cycle after edge E(2^DW).
REQ-030 SHALL, without HIST_READY_EN, have no hist_ready port and leave all other behaviour unchanged.

Verification (DW=8, IW=4, IH=2, TW=32)
REQ-031 SHALL verify: reset release, addresses 0, 128, 255 read -> hist_cnt_out=0.
REQ-032 SHALL verify: frame of pixels 0,0,5,5,5,255,10,10 then vsync fall, wait 257 cycles -> CDF[0]=2, CDF[4]=2, CDF[5]=5, CDF[9]=5, CDF[10]=7, CDF[254]=7, CDF[255]=8.
REQ-033 SHALL verify: second frame of eight pixels all 3 -> CDF[2]=0, CDF[3]=8, CDF[255]=8, confirming CNT was cleared.
REQ-034 SHALL verify: a frame containing extra din=7 samples with din_valid=0 or with vsync=0 -> those samples are absent from CDF (CDF[7] is unchanged by them).
REQ-035 SHALL verify: rst_n pulsed low mid-pass (about 100 cycles after E0) -> all addresses read 0.
REQ-036 SHALL verify: with HIST_READY_EN defined -> hist_ready is high only in the cycle after E256, once per frame.
